// File: rtl/fpdiv_arbiter.sv
// fpdiv_arbiter
//   Round-robin sequencer sharing one combinational single-precision divider
//   among NREQ requesters. One request is accepted at a time. Its operands are
//   registered onto div_x/div_y, the divider is given LAT cycles to settle,
//   and the captured quotient is returned with the requester ID.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot or zero)
//   req_x/req_y             packed operands, requester i at [32*i+31:32*i]
//   resp_valid/resp_ready   response handshake
//   resp_q, resp_id         quotient and owning requester ID
//   div_x, div_y, div_q     registered operands to / quotient from the divider
//   busy                    high while an operation is outstanding
//
// Optional feature: define FPDIV_ZERO_BYPASS_EN to answer divide-by-zero
// requests directly (Inf or quiet NaN) without touching the divider.

module fpdiv_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_x,
  input  logic [32*NREQ-1:0] req_y,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_q,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       div_x,
  output logic [31:0]       div_y,
  input  logic [31:0]       div_q,
  output logic              busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] id;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant;
  logic           grant_found;
  logic           accept;
  logic [31:0]    sel_x, sel_y;
  logic           bypass;

  // Round-robin pick: first valid requester after the last one granted.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant       = IDW'(idx);
        grant_found = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;
  assign sel_x  = req_x[32*grant +: 32];
  assign sel_y  = req_y[32*grant +: 32];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

`ifdef FPDIV_ZERO_BYPASS_EN
  logic [31:0] bypass_q;
  logic        x_zero, x_nan;

  // Divisor of +/-0: 0/0 and NaN/0 give quiet NaN, anything else signed Inf.
  assign bypass   = (sel_y[30:0] == 31'd0);
  assign x_zero   = (sel_x[30:0] == 31'd0);
  assign x_nan    = (sel_x[30:23] == 8'hFF) && (sel_x[22:0] != 23'd0);
  assign bypass_q = (x_zero || x_nan) ? 32'h7FC0_0000
                                      : {sel_x[31] ^ sel_y[31], 8'hFF, 23'd0};
`else
  assign bypass = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = bypass ? RESP : CALC;
      CALC: if (cnt == '0) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      id         <= '0;
      last_grant <= IDW'(NREQ - 1);
      div_x      <= '0;
      div_y      <= '0;
      resp_q     <= '0;
      resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id         <= grant;
            last_grant <= grant;
            cnt        <= CW'(LAT - 1);
`ifdef FPDIV_ZERO_BYPASS_EN
            if (bypass) begin
              // Divider operands are left untouched on a bypassed request.
              resp_q  <= bypass_q;
              resp_id <= grant;
            end else begin
              div_x <= sel_x;
              div_y <= sel_y;
            end
`else
            div_x <= sel_x;
            div_y <= sel_y;
`endif
          end
        end
        CALC: begin
          if (cnt == '0) begin
            resp_q  <= div_q;
            resp_id <= id;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Testbench for fpdiv_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model. A stand-in
// divider only presents a correct quotient once its inputs have been stable
// for LAT cycles, so capturing early yields a visibly wrong value.

module tb_fpdiv_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;
`ifdef FPDIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_x, req_y;
  logic              resp_valid, resp_ready;
  logic [31:0]       resp_q;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       div_x, div_y;
  logic [31:0]       div_q = 32'd0;
  logic              busy;

  int total = 0;
  int bad   = 0;

  fpdiv_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_q(resp_q), .resp_id(resp_id),
    .div_x(div_x), .div_y(div_y), .div_q(div_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in divider: one known real quotient, otherwise a scrambling function.
  function automatic logic [31:0] fdiv(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h3FF33398 && y == 32'h3F816990) return 32'h3FF08C1E;
    return {x[15:0] ^ y[31:16], x[31:16] + y[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] zero_div(input logic [31:0] x, input logic [31:0] y);
    if (x[30:0] == 31'd0) return 32'h7FC0_0000;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'h7FC0_0000;
    return {x[31] ^ y[31], 8'hFF, 23'd0};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Divider settling model.
  initial begin
    logic [63:0] prev;
    int age;
    prev = '0;
    age  = 0;
    forever begin
      @(negedge clk);
      if ({div_x, div_y} != prev) begin
        prev = {div_x, div_y};
        age  = 1;
      end else if (age < 1000) begin
        age++;
      end
      div_q = (age >= LAT) ? fdiv(div_x, div_y) : 32'hBAD0_BAD0;
    end
  end

  // Transaction-level model and per-cycle compare.
  initial begin
    bit          m_busy;
    int          m_last, m_id, m_resp_cyc, cyc, g;
    logic [31:0] m_q, m_divx, m_divy, m_respq;
    int          m_respid;
    logic [31:0] x, y;
    logic [NREQ-1:0] exp_ready;
    bit          exp_rv;
    m_busy = 0; m_last = NREQ - 1; m_id = 0; m_resp_cyc = 0; cyc = 0;
    m_q = 0; m_divx = 0; m_divy = 0; m_respq = 0; m_respid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 0; m_last = NREQ - 1;
        m_divx = 0; m_divy = 0; m_respq = 0; m_respid = 0;
      end
      exp_rv = m_busy && (cyc >= m_resp_cyc);
      g = m_busy ? -1 : rr_pick(req_valid, m_last);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("model resp_valid", resp_valid, exp_rv);
      chk("model busy", busy, m_busy);
      chk("model req_ready", req_ready, exp_ready);
      chk("model resp_q", resp_q, m_respq);
      chk("model resp_id", resp_id, m_respid);
      chk("model div_x", div_x, m_divx);
      chk("model div_y", div_y, m_divy);
      if (!reset) begin
        if (exp_rv && resp_ready) begin
          m_busy = 0;
        end else if (g >= 0) begin
          x = req_x[32*g +: 32];
          y = req_y[32*g +: 32];
          m_busy = 1; m_last = g; m_id = g;
          if (BYP && y[30:0] == 31'd0) begin
            m_q = zero_div(x, y);
            m_resp_cyc = cyc + 1;
          end else begin
            m_divx = x; m_divy = y;
            m_q = fdiv(x, y);
            m_resp_cyc = cyc + LAT + 1;
          end
        end
        if (m_busy && cyc + 1 == m_resp_cyc) begin
          m_respq = m_q; m_respid = m_id;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    samp();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    samp();
    while (busy && w < 20) begin
      tick(); samp(); w++;
    end
    chk("drain busy timeout", busy, 1'b0);
    tick();
  endtask

  // Single request from an idle DUT with resp_ready=1; response expected lat cycles later.
  task automatic dir_op(input int port, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] q, input int lat);
    logic [NREQ-1:0] v;
    v = 4'b0001;
    v = v << port;
    set_req(port, x, y);
    req_valid = v;
    samp();
    chk("op req_ready", req_ready, v);
    tick();
    req_valid = '0;
    for (int k = 1; k <= lat; k++) begin
      samp();
      chk("op resp_valid timing", resp_valid, (k == lat));
      if (k == lat) begin
        chk("op resp_q", resp_q, q);
        chk("op resp_id", resp_id, port);
      end
      tick();
    end
  endtask

  initial begin
    int exp_ids [5];
    int ids [5];
    int n, w;
    logic [31:0] x, y;
    exp_ids = '{0, 1, 2, 3, 0};
    ids = '{0, 0, 0, 0, 0};
    reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; resp_ready = 1'b1;
    tick(); tick();
    samp();
    chk("reset resp_valid", resp_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset div_x", div_x, 32'd0);
    chk("reset resp_q", resp_q, 32'd0);
    chk("reset req_ready", req_ready, 4'b0000);
    tick();
    reset = 1'b0;

    // Known quotient through port 2.
    dir_op(2, 32'h3FF33398, 32'h3F816990, 32'h3FF08C1E, LAT + 1);

    // All requesters busy: strict rotation from port 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, 32'h4000_0000 | i);
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      samp();
      chk("rot onehot", ($countones(req_ready) <= 1), 1'b1);
      if (resp_valid && resp_ready) begin
        ids[n] = resp_id;
        n++;
      end
      tick();
    end
    req_valid = '0;
    chk("rot count", n, 5);
    for (int i = 0; i < 5; i++) chk("rot resp_id order", ids[i], exp_ids[i]);
    tick();

    // Back-pressure on the response channel.
    x = 32'h4120_0000; y = 32'h4040_0000;
    resp_ready = 1'b0;
    set_req(1, x, y);
    req_valid = 4'b0010;
    samp();
    chk("bp req_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'hF;
    w = 0;
    samp();
    while (!resp_valid && w < 10) begin
      tick(); samp(); w++;
    end
    chk("bp resp_valid timeout", resp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp resp_valid held", resp_valid, 1'b1);
      chk("bp resp_q held", resp_q, fdiv(x, y));
      chk("bp resp_id held", resp_id, 1);
      chk("bp req_ready low", req_ready, 4'b0000);
      chk("bp busy", busy, 1'b1);
      tick();
      if (i == 4) resp_ready = 1'b1;
      samp();
    end
    chk("bp handshake resp_valid", resp_valid, 1'b1);
    chk("bp handshake req_ready", req_ready, 4'b0000);
    tick();
    samp();
    chk("bp next grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    drain();

    // Reset while in CALC.
    set_req(3, 32'h4100_0000, 32'h4040_0000);
    req_valid = 4'b1000;
    samp();
    chk("abort req_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    #2 reset = 1'b1;
    #1;
    chk("abort async resp_valid", resp_valid, 1'b0);
    chk("abort async div_x", div_x, 32'd0);
    chk("abort async resp_q", resp_q, 32'd0);
    chk("abort async busy", busy, 1'b0);
    samp();
    tick();
    reset = 1'b0;
    req_valid = 4'hF;
    samp();
    chk("abort first grant", req_ready, 4'b0001);
    chk("abort no response", resp_valid, 1'b0);
    tick();
    req_valid = '0;
    drain();

    // Zero divisors.
    dir_op(1, 32'h3F80_0000, 32'h8000_0000,
           BYP ? 32'hFF80_0000 : fdiv(32'h3F80_0000, 32'h8000_0000), BYP ? 1 : LAT + 1);
    dir_op(0, 32'h0000_0000, 32'h0000_0000,
           BYP ? 32'h7FC0_0000 : fdiv(32'h0, 32'h0), BYP ? 1 : LAT + 1);

    // Random traffic, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid  = NREQ'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: x = $urandom & 32'h8000_0000;
            1: x = 32'h7F80_0001 | ($urandom & 32'h807F_FFFF);
            default: x = $urandom;
          endcase
          y = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h8000_0000) : $urandom;
          set_req(i, x, y);
        end
      end
      tick();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpdiv_arbiter.md
Name: fpdiv_arbiter

Overview:
Round-robin sequencer that shares one combinational single-precision divider (fpdiv) among NREQ requesters. It accepts one request at a time over a valid/ready handshake and registers the operands onto the divider inputs. It then waits a fixed multicycle settling time (LAT cycles), captures the quotient and returns it with the requester ID over a valid/ready response channel. It sits between client units and the fpdiv instance, and drives the divider's operand ports directly.

Parameters:
NREQ, 4, number of requesters (>=2)
LAT, 2, cycles fpdiv is given to settle after operands change (>=1)
IDW, $clog2(NREQ), width of requester ID

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_x  in  32*NREQ  dividends, requester i at [32*i+31:32*i]
req_y  in  32*NREQ  divisors, same packing
resp_valid  out  1  result valid
resp_ready  in  1  result consumed
resp_q  out  32  quotient
resp_id  out  IDW  ID of requester that owns resp_q
div_x  out  32  registered dividend to fpdiv
div_y  out  32  registered divisor to fpdiv
div_q  in  32  quotient from fpdiv
busy  out  1  state != IDLE

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high. While reset is high:
  - state=IDLE; resp_valid, resp_q, resp_id, div_x, div_y, cnt = 0.
  - last_grant = NREQ-1, so requester 0 has first priority.
- Reset mid-operation aborts the operation; no response is ever produced for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], scanning from last_grant+1 mod NREQ with wrap-around.
  - req_ready[g]=1 combinationally; all others 0; req_ready=0 when no valid request.
  - Accept on req_valid[g] & req_ready[g]. On accept: div_x<=req_x[g], div_y<=req_y[g], id<=g, last_grant<=g, cnt<=LAT-1, state->CALC.
  - Arbitration is recomputed every IDLE cycle. A requester may drop req_valid without a handshake.
- CALC:
  - req_ready=0. cnt decrements each cycle.
  - When cnt==0: resp_q<=div_q, resp_id<=id, state->RESP.
- RESP:
  - resp_valid=1; resp_q and resp_id held stable; req_ready=0.
  - On resp_valid & resp_ready: state->IDLE. No accept happens in the same cycle as the response handshake.
- Latency: accept in cycle N -> resp_valid first high in cycle N+LAT+1.
- Minimum issue interval: LAT+2 cycles.
- div_x and div_y hold their value until the next accept; they are not cleared on return to IDLE.
- last_grant changes only on accept.
- busy=1 in CALC and RESP.

Optional Feature:
Macro FPDIV_ZERO_BYPASS_EN.
- Defined: at accept, if req_y[g][30:0]==0 the operation skips CALC.
  - State goes directly to RESP; resp_valid first high in cycle N+1.
  - resp_q = 32'h7FC00000 if the dividend is zero ([30:0]==0) or NaN (exp=8'hFF, frac!=0).
  - Otherwise resp_q = {x[31]^y[31], 8'hFF, 23'h0}.
  - div_x and div_y are not updated; last_grant and resp_id update normally.
- Undefined: every request goes through CALC, and resp_q = div_q.

Test Plan:
- Bench instantiates fpdiv on div_x/div_y/div_q, LAT=2, resp_ready=1. Port 2 requests x=3FF33398, y=3F816990 -> req_ready[2] high in cycle N; resp_valid high only in cycle N+3 with resp_q=3FF08C1E, resp_id=2.
- All four req_valid held high after reset -> accept order 0,1,2,3,0; resp_id sequence matches; req_ready never multi-hot.
- resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_q, resp_id stable; req_ready=0; busy=1. Next accept occurs only in the cycle after the response handshake.
- Reset pulsed during CALC -> resp_valid, div_x, resp_q = 0 immediately (asynchronous). No response after release; first grant afterwards goes to port 0.
- With FPDIV_ZERO_BYPASS_EN:
  - x=3F800000, y=80000000 -> resp_q=FF800000 in cycle N+1.
  - x=00000000, y=00000000 -> resp_q=7FC00000.
  - Without the macro, the same stimulus responds in cycle N+3 with the div_q value.
